// File: rtl/down_timer.sv
`timescale 1ns/1ps
// Loadable down-counter/timer: counts a preloaded value to zero, flags terminal count, optional auto-reload.
// Latency: load visible on count one cycle after the load edge; tc high in the cycle after the terminal edge.
// Backpressure: none; enable low pauses the count (HOLD), load always wins over enable.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             running,
    output logic             paused
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nxt;
    logic             tc_nxt;

    // Next-state, next-count and terminal-count decision; load overrides everything.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;

        if (load) begin
            // A zero load parks the timer in IDLE since there is nothing to count.
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != CNT_ZERO) ? S_HOLD : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // Nothing loaded yet: enable alone does nothing.
                    state_nxt = S_IDLE;
                end

                S_HOLD, S_RUN: begin
                    if (enable) begin
                        if (count == CNT_ONE) begin
                            // Terminal edge. HOLD with count=1 is also terminal so
                            // the counter can never sit in RUN at zero.
                            tc_nxt = 1'b1;
                            if (auto_reload && (reload_q != CNT_ZERO)) begin
                                count_nxt = reload_q;
                                state_nxt = S_RUN;
                            end else begin
                                count_nxt = CNT_ZERO;
                                state_nxt = S_DONE;
                            end
                        end else if (count > CNT_ONE) begin
                            count_nxt = count - CNT_ONE;
                            state_nxt = S_RUN;
                        end else begin
                            // Count of zero outside IDLE/DONE is unreachable; recover to IDLE
                            // rather than wrapping.
                            count_nxt = CNT_ZERO;
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        // Pausing keeps the count; HOLD simply stays HOLD.
                        state_nxt = S_HOLD;
                    end
                end

                S_DONE: begin
                    // Sticky until load or reset.
                    count_nxt = CNT_ZERO;
                    state_nxt = S_DONE;
                end

                default: begin
                    count_nxt = CNT_ZERO;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, count, reload value and tc pulse registers with immediate async clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            tc       <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            reload_q <= reload_nxt;
            tc       <= tc_nxt;
        end
    end

    // Status levels decode straight from the state register, so they are glitch-free.
    assign running = (state == S_RUN);
    assign paused  = (state == S_HOLD);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_down_timer.sv
`timescale 1ns/1ps
// Bench for down_timer: directed vector table, async-reset sequence, then random traffic vs reference model.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: not applicable.
module tb_down_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             running;
    logic             paused;

    int n_checks;
    int n_fail;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .done        (done),
        .running     (running),
        .paused      (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ld;
        logic [3:0] lv;
        logic       ar;
        logic [3:0] e_cnt;
        logic       e_tc;
        logic       e_done;
        logic       e_run;
        logic       e_pause;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: remaining count, stored start value, and whether a
    // nonzero count is live / actively counting / finished.
    int m_cnt;
    int m_rel;
    bit m_live;
    bit m_run;
    bit m_done;
    bit m_tc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_cnt, input logic e_tc,
                           input logic e_done, input logic e_run, input logic e_pause);
        chk({tag, ".count"},   32'(count),   32'(e_cnt));
        chk({tag, ".tc"},      32'(tc),      32'(e_tc));
        chk({tag, ".done"},    32'(done),    32'(e_done));
        chk({tag, ".running"}, 32'(running), 32'(e_run));
        chk({tag, ".paused"},  32'(paused),  32'(e_pause));
    endtask

    // Drive one cycle of inputs at the falling edge, wait for the rising edge.
    task automatic drive(input logic en, input logic ld, input logic [3:0] lv, input logic ar);
        @(negedge clk);
        enable      = en;
        load        = ld;
        load_val    = lv;
        auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic ld, input logic [3:0] lv, input logic ar,
                       input logic [3:0] c, input logic t, input logic d, input logic r, input logic p);
        vec_t v;
        v.en = en; v.ld = ld; v.lv = lv; v.ar = ar;
        v.e_cnt = c; v.e_tc = t; v.e_done = d; v.e_run = r; v.e_pause = p;
        vecs.push_back(v);
    endtask

    // One clock of the timer's rules, expressed on the model's own variables.
    task automatic model_step(input bit en, input bit ld, input int lv, input bit ar);
        m_tc = 1'b0;
        if (ld) begin
            m_cnt  = lv;
            m_rel  = lv;
            m_live = (lv != 0);
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (m_live) begin
            if (en) begin
                if (m_cnt == 1) begin
                    m_tc = 1'b1;
                    if (ar && m_rel != 0) begin
                        m_cnt = m_rel;
                        m_run = 1'b1;
                    end else begin
                        m_cnt  = 0;
                        m_live = 1'b0;
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                    m_run = 1'b1;
                end
            end else begin
                m_run = 1'b0;
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        auto_reload = 1'b0;

        // Reset state, checked before any clock edge has occurred.
        #3;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        reset = 1'b0;

        //   en  ld  lv  ar   cnt tc dn rn ps
        add(1, 0, 0, 0,   0, 0, 0, 0, 0);   // enable alone in IDLE
        add(0, 1, 5, 0,   5, 0, 0, 0, 1);   // load 5
        add(1, 0, 0, 0,   4, 0, 0, 1, 0);
        add(1, 0, 0, 0,   3, 0, 0, 1, 0);
        add(1, 0, 0, 0,   2, 0, 0, 1, 0);
        add(1, 0, 0, 0,   1, 0, 0, 1, 0);
        add(1, 0, 0, 0,   0, 1, 1, 0, 0);   // terminal edge
        add(1, 0, 0, 0,   0, 0, 1, 0, 0);   // done sticky, no wrap
        add(1, 0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 1, 9, 0,   9, 0, 0, 0, 1);   // load from DONE
        add(1, 0, 0, 0,   8, 0, 0, 1, 0);
        add(1, 0, 0, 0,   7, 0, 0, 1, 0);
        add(1, 0, 0, 0,   6, 0, 0, 1, 0);
        add(0, 0, 0, 0,   6, 0, 0, 0, 1);   // pause x4
        add(0, 0, 0, 0,   6, 0, 0, 0, 1);
        add(0, 0, 0, 0,   6, 0, 0, 0, 1);
        add(0, 0, 0, 0,   6, 0, 0, 0, 1);
        add(1, 0, 0, 0,   5, 0, 0, 1, 0);   // resume
        add(1, 0, 0, 0,   4, 0, 0, 1, 0);
        add(1, 1, 7, 0,   7, 0, 0, 0, 1);   // load beats enable in RUN
        add(0, 1, 3, 1,   3, 0, 0, 0, 1);   // periodic mode
        add(1, 0, 0, 1,   2, 0, 0, 1, 0);
        add(1, 0, 0, 1,   1, 0, 0, 1, 0);
        add(1, 0, 0, 1,   3, 1, 0, 1, 0);
        add(1, 0, 0, 1,   2, 0, 0, 1, 0);
        add(1, 0, 0, 1,   1, 0, 0, 1, 0);
        add(1, 0, 0, 1,   3, 1, 0, 1, 0);
        add(1, 0, 0, 1,   2, 0, 0, 1, 0);
        add(1, 1, 0, 1,   0, 0, 0, 0, 0);   // zero load -> IDLE
        add(1, 0, 0, 0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ld, vecs[i].lv, vecs[i].ar);
            chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_tc,
                    vecs[i].e_done, vecs[i].e_run, vecs[i].e_pause);
        end

        // Async reset in the middle of a count.
        drive(0, 1, 9, 0);
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 0);
        chk("pre_rst.count", 32'(count), 32'd5);
        chk("pre_rst.running", 32'(running), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            chk_all($sformatf("post_rst%0d", k), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Random traffic against the model, which starts from the reset state.
        m_cnt = 0; m_rel = 0; m_live = 0; m_run = 0; m_done = 0; m_tc = 0;
        for (int k = 0; k < 600; k++) begin
            logic       r_en;
            logic       r_ld;
            logic [3:0] r_lv;
            logic       r_ar;
            r_en = ($urandom_range(0, 3) != 0);
            r_ld = ($urandom_range(0, 9) == 0);
            r_lv = 4'($urandom_range(0, 15));
            r_ar = ($urandom_range(0, 1) == 1);
            drive(r_en, r_ld, r_lv, r_ar);
            model_step(r_en, r_ld, int'(r_lv), r_ar);
            chk_all($sformatf("rand%0d", k), 4'(m_cnt), m_tc, m_done, m_run, m_live && !m_run);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counter/timer: counts a preloaded value toward zero while enabled, then signals terminal count.
- Optional auto-reload for periodic ticks.
- Sits beside the existing 4-bit up-counter in the Assignment-1 blocks and reuses the same clk/reset/enable control style.
- Serves as the countdown side of the counter pair: it consumes a start value instead of producing an incrementing count.

Parameters:
- WIDTH, 4, width of count, load_val and the internal reload register.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count-down enable, sampled on rising clk.
- load  input  1  load strobe, sampled on rising clk.
- load_val  input  WIDTH  start/reload value, captured when load=1.
- auto_reload  input  1  1 = reload from the stored value at terminal count; 0 = stop in DONE.
- count  output  WIDTH  current count value (registered).
- tc  output  1  terminal-count pulse, high for exactly one cycle.
- done  output  1  level, high while in DONE.
- running  output  1  high while in RUN.
- paused  output  1  high while in HOLD.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset takes effect immediately on assertion, without waiting for clk, including mid-count. While reset=1:
  - state=IDLE
  - count=0 and reload register=0
  - tc=0, done=0, running=0, paused=0
- On reset deassertion, the first active edge is the next rising clk.
- All outputs are registered. running, paused and done decode directly from the state register.
- States and transitions:
  - IDLE: count holds. load=1 with load_val!=0 -> HOLD. load=1 with load_val=0 -> IDLE. enable alone has no effect.
  - HOLD: count holds. enable=1 -> RUN, and count decrements on that same edge.
  - RUN: enable=1 and count>1 -> count-1, stay in RUN. enable=0 -> HOLD, count holds.
  - RUN, terminal edge (enable=1, count=1), auto_reload=1 and reload register!=0: count <= reload register, tc=1 for one cycle, stay in RUN. Period is exactly N enabled cycles.
  - RUN, terminal edge, auto_reload=0: count <= 0, tc=1 for one cycle, go to DONE.
  - DONE: count=0. Sticky until load or reset. enable is ignored.
- Load:
  - On any load edge, load_val is written to both count and the reload register.
  - load has priority over enable in every state, including RUN and DONE.
  - load=1 and enable=1 on the same edge: load wins and no decrement occurs. Next state is HOLD if load_val!=0, else IDLE.
  - tc is never asserted on a load edge.
- Arithmetic:
  - Unsigned.
  - Count never wraps below 0. Decrement only occurs when count>=1.
- auto_reload is sampled only on the terminal edge. Changing it mid-count has no other effect.
- Latency:
  - count reflects a load one cycle after the load edge (visible after the edge).
  - tc is high in the cycle immediately following the terminal edge.

Test Plan:
- Reset is async at t=0, deasserted at t=7 (10-unit clk period) -> all outputs 0 and state IDLE. enable=1 alone keeps count=0 and running=0.
- load_val=5, load one cycle, then enable held high, auto_reload=0:
  - count steps 5,4,3,2,1,0 over 5 enabled edges.
  - tc is high for exactly one cycle as count reaches 0.
  - done=1 stays high with further enables; count stays 0, no wrap.
- Pause: load 9, enable for 3 edges (count=6), drop enable for 4 edges -> paused=1 and count holds 6. Re-enable -> 5 on the next edge.
- auto_reload=1, load 3, enable continuously:
  - count sequence is 3,2,1,3,2,1,...
  - tc pulses every 3 cycles; done never asserts.
- Priority and corners:
  - load=1 with enable=1 while count=4, load_val=7 -> count=7, no decrement, paused=1.
  - load_val=0 -> state IDLE, tc stays 0.
- Async reset mid-count: assert reset between clock edges while count=5 in RUN -> count=0 and running=0 before the next clk edge. After release, enable=1 does not count until a new load.
